// File: rtl/noc_local_inject_queue.sv
// noc_local_inject_queue: injection FIFO between a tile flit source and the
// router local (P) port. Valid/ready on the tile side, void/stop on the router
// side, registered output stage, packet framing check with a sticky error.
// Optional feature macro: NOC_INJECT_PKT_ATOMIC_EN (hold a head flit back until
// its whole packet is stored or the FIFO is full).
module noc_local_inject_queue #(
  parameter int Width = 66,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [Width-1:0]         in_data,
  output logic [Width-1:0]         data_p_out,
  output logic                     data_void_p_out,
  input  logic                     stop_p_in,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic                     proto_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic {
    IDLE,
    IN_PKT
  } frame_state_e;

  logic [Width-1:0] mem_q [DEPTH];
  logic [Width-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [Width-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  frame_state_e     state_q, state_d;
  logic             proto_err_q, proto_err_d;

  logic push;
  logic load_slot;
  logic fifo_empty;
  logic fifo_rd;
  logic fifo_wr;
  logic bypass;
  logic head_ok;
  logic bypass_ok;

  // Ready comes from the registered count only, and is held low while in reset.
  assign in_ready   = rst && (count_q != FULL);
  assign push       = in_valid && in_ready;
  assign load_slot  = !out_valid_q || !stop_p_in;
  assign fifo_empty = (count_q == '0);

`ifdef NOC_INJECT_PKT_ATOMIC_EN
  logic [CW-1:0] pkt_cnt_q, pkt_cnt_d;

  // A head may leave the FIFO only once its packet is complete (a stored tail,
  // or a tail arriving this cycle), or when the FIFO is full and must drain.
  assign head_ok   = !mem_q[rd_ptr_q][Width-1] || (pkt_cnt_q != '0) ||
                     (push && in_data[Width-2]) || (count_q == FULL);
  assign bypass_ok = !in_data[Width-1] || in_data[Width-2];

  // Count complete packets held in the FIFO: tails written in, tails read out.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q + CW'(fifo_wr && in_data[Width-2])
                          - CW'(fifo_rd && mem_q[rd_ptr_q][Width-2]);
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (!rst) pkt_cnt_q <= '0;
    else      pkt_cnt_q <= pkt_cnt_d;
  end
`else
  assign head_ok   = 1'b1;
  assign bypass_ok = 1'b1;
`endif

  assign fifo_rd = load_slot && !fifo_empty && head_ok;
  assign bypass  = load_slot && fifo_empty && push && bypass_ok;
  assign fifo_wr = push && !bypass;

  // FIFO storage, pointers and occupancy bookkeeping.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (fifo_wr) begin
      mem_d[wr_ptr_q] = in_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (fifo_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    count_d = count_q + CW'(fifo_wr) - CW'(fifo_rd);
  end

  // Output stage: reload when void or popped; an empty FIFO lets a fresh push straight in.
  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (load_slot) begin
      if (fifo_rd) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q];
      end else if (bypass) begin
        out_valid_d = 1'b1;
        out_data_d  = in_data;
      end else begin
        out_valid_d = 1'b0;
        out_data_d  = '0;
      end
    end
  end

  // Framing FSM watching every accepted flit; errors are sticky until reset.
  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    if (push) begin
      case (state_q)
        IDLE: begin
          if (!in_data[Width-1]) proto_err_d = 1'b1;
          else                   state_d = in_data[Width-2] ? IDLE : IN_PKT;
        end
        IN_PKT: begin
          if (in_data[Width-1]) begin
            proto_err_d = 1'b1;
            state_d     = in_data[Width-2] ? IDLE : IN_PKT;
          end else if (in_data[Width-2]) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Control and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      state_q     <= IDLE;
      proto_err_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      state_q     <= state_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Storage array; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign data_p_out      = out_data_q;
  assign data_void_p_out = !out_valid_q;
  assign occupancy       = count_q;
  assign proto_err       = proto_err_q;

endmodule

// File: tb/tb_noc_local_inject_queue.sv
// Testbench for noc_local_inject_queue: queue-level reference model checked
// every cycle, plus directed scenarios with hand-computed expectations.
module tb_noc_local_inject_queue;

  localparam int Width = 66;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [Width-1:0] flit_t;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           in_valid = 1'b0;
  logic           in_ready;
  flit_t          in_data = '0;
  flit_t          data_p_out;
  logic           data_void_p_out;
  logic           stop_p_in = 1'b0;
  logic [CW-1:0]  occupancy;
  logic           proto_err;

  int n_cmp  = 0;
  int n_fail = 0;

  flit_t mq[$];
  bit    mv;
  bit    merr;
  bit    mpkt;
  bit    started = 1'b0;
  flit_t out_log[$];

  noc_local_inject_queue #(.Width(Width), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .data_p_out      (data_p_out),
    .data_void_p_out (data_void_p_out),
    .stop_p_in       (stop_p_in),
    .occupancy       (occupancy),
    .proto_err       (proto_err)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  function automatic flit_t mk(input logic h, input logic t, input logic [63:0] p);
    return {h, t, p};
  endfunction

  function automatic flit_t streamFlit(input int n);
    return mk((n % 3) == 0, (n % 3) == 2, 64'(200 + n));
  endfunction

  // Whether the model lets the front flit into the output register.
  function automatic bit gateOk(input int prev_occ);
`ifdef NOC_INJECT_PKT_ATOMIC_EN
    if (!mq[0][Width-1]) return 1'b1;
    if (prev_occ == DEPTH) return 1'b1;
    foreach (mq[i]) if (mq[i][Width-2]) return 1'b1;
    return 1'b0;
`else
    return (prev_occ >= 0);
`endif
  endfunction

  task automatic checkOutput(input string name, input flit_t act, input flit_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input flit_t d, input logic s, output logic acc);
    in_valid  = v;
    in_data   = d;
    stop_p_in = s;
    #1;
    acc = in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic pushFlit(input flit_t d, input logic s);
    logic acc;
    int   tries;
    tries = 0;
    do begin
      applyStimulus(1'b1, d, s, acc);
      tries++;
    end while (!acc && tries < 16);
    checkOutput("push_accepted", Width'(acc), Width'(1'b1));
  endtask

  // Reference model: queue of every flit in flight, front is the presented one.
  always @(posedge clk) begin
    int prev_occ;
    bit push;
    bit popped;
    if (!rst) begin
      mq.delete();
      mv      = 1'b0;
      merr    = 1'b0;
      mpkt    = 1'b0;
      started = 1'b1;
    end else if (started) begin
      if (!data_void_p_out && !stop_p_in) out_log.push_back(data_p_out);
      prev_occ = mq.size() - int'(mv);
      push     = in_valid && (prev_occ != DEPTH);
      popped   = mv && !stop_p_in;
      if (popped) void'(mq.pop_front());
      if (push) begin
        if (!mpkt) begin
          if (!in_data[Width-1]) merr = 1'b1;
          else                   mpkt = !in_data[Width-2];
        end else if (in_data[Width-1]) begin
          merr = 1'b1;
          mpkt = !in_data[Width-2];
        end else if (in_data[Width-2]) begin
          mpkt = 1'b0;
        end
        mq.push_back(in_data);
      end
      if (!(mv && !popped)) mv = (mq.size() > 0) && gateOk(prev_occ);
    end
  end

  // Compare every DUT output against the model away from the active edge.
  always @(negedge clk) begin
    int occ;
    if (started) begin
      occ = mq.size() - int'(mv);
      checkOutput("void", Width'(data_void_p_out), Width'(!mv));
      checkOutput("data", data_p_out, mv ? mq[0] : flit_t'(0));
      checkOutput("occupancy", Width'(occupancy), Width'(occ));
      checkOutput("in_ready", Width'(in_ready), Width'(rst && (occ != DEPTH)));
      checkOutput("proto_err", Width'(proto_err), Width'(merr));
    end
  end

  // Directed scenarios.
  initial begin
    logic  acc;
    flit_t f[6];
    flit_t exp1;
    flit_t hf, bf, tf;
    int    cur;

    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, acc);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("rst_void", Width'(data_void_p_out), Width'(1'b1));
    checkOutput("rst_data", data_p_out, '0);
    checkOutput("rst_occ", Width'(occupancy), '0);
    checkOutput("rst_ready", Width'(in_ready), '0);
    checkOutput("rst_err", Width'(proto_err), '0);
    rst = 1'b1;
    #1;
    checkOutput("ready_after_rst", Width'(in_ready), Width'(1'b1));

    $display("[TB] single flit");
    exp1 = 66'h3_0000_0000_0000_00A5;
    applyStimulus(1'b1, mk(1'b1, 1'b1, 64'hA5), 1'b0, acc);
    checkOutput("single_void", Width'(data_void_p_out), '0);
    checkOutput("single_data", data_p_out, exp1);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("single_void_after", Width'(data_void_p_out), Width'(1'b1));
    checkOutput("single_occ_after", Width'(occupancy), '0);

    $display("[TB] backpressure fill");
    out_log.delete();
    f[0] = mk(1'b1, 1'b0, 64'h100);
    for (int i = 1; i < 5; i++) f[i] = mk(1'b0, 1'b0, 64'(256 + i));
    f[5] = mk(1'b0, 1'b1, 64'h105);
    for (int i = 0; i < 5; i++) pushFlit(f[i], 1'b1);
`ifndef NOC_INJECT_PKT_ATOMIC_EN
    checkOutput("fill_ready", Width'(in_ready), '0);
    checkOutput("fill_occ", Width'(occupancy), Width'(4));
    checkOutput("fill_head", data_p_out, f[0]);
    applyStimulus(1'b1, f[5], 1'b1, acc);
    checkOutput("fill_push6_blocked", Width'(acc), '0);
`endif
    pushFlit(f[5], 1'b0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("fill_count", Width'(out_log.size()), Width'(6));
    for (int i = 0; i < 6 && i < out_log.size(); i++) checkOutput("fill_order", out_log[i], f[i]);

    $display("[TB] push/pop at full with stop toggling");
    out_log.delete();
    cur = 0;
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, streamFlit(cur), logic'(i % 2 == 0), acc);
      if (acc) cur++;
      checkOutput("occ_le_depth", Width'(occupancy <= CW'(DEPTH)), Width'(1'b1));
    end
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("stream_count", Width'(out_log.size()), Width'(cur));
    for (int i = 0; i < out_log.size(); i++) checkOutput("stream_order", out_log[i], streamFlit(i));

    $display("[TB] framing error");
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, acc);
    rst = 1'b1;
    applyStimulus(1'b1, mk(1'b0, 1'b0, 64'h300), 1'b0, acc);
    checkOutput("err_set", Width'(proto_err), Width'(1'b1));
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, acc);
    applyStimulus(1'b1, mk(1'b1, 1'b1, 64'h301), 1'b0, acc);
    checkOutput("err_sticky", Width'(proto_err), Width'(1'b1));

    $display("[TB] reset mid-packet");
    applyStimulus(1'b1, mk(1'b1, 1'b0, 64'h400), 1'b1, acc);
    applyStimulus(1'b1, mk(1'b0, 1'b0, 64'h401), 1'b1, acc);
    rst = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("midrst_void", Width'(data_void_p_out), Width'(1'b1));
    checkOutput("midrst_occ", Width'(occupancy), '0);
    checkOutput("midrst_err", Width'(proto_err), '0);
    rst = 1'b1;
    out_log.delete();
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("midrst_no_stale", Width'(out_log.size()), '0);
    checkOutput("midrst_void_after", Width'(data_void_p_out), Width'(1'b1));

    $display("[TB] packet atomicity");
    hf = mk(1'b1, 1'b0, 64'h500);
    bf = mk(1'b0, 1'b0, 64'h501);
    tf = mk(1'b0, 1'b1, 64'h502);
    applyStimulus(1'b1, hf, 1'b0, acc);
`ifdef NOC_INJECT_PKT_ATOMIC_EN
    for (int i = 0; i < 5; i++) begin
      checkOutput("atomic_wait_void", Width'(data_void_p_out), Width'(1'b1));
      applyStimulus(1'b0, '0, 1'b0, acc);
    end
    applyStimulus(1'b1, bf, 1'b0, acc);
    checkOutput("atomic_body_void", Width'(data_void_p_out), Width'(1'b1));
    applyStimulus(1'b1, tf, 1'b0, acc);
    checkOutput("atomic_head", data_p_out, hf);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("atomic_body", data_p_out, bf);
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("atomic_tail", data_p_out, tf);
`else
    checkOutput("fwd_head", data_p_out, hf);
    applyStimulus(1'b1, bf, 1'b0, acc);
    checkOutput("fwd_body", data_p_out, bf);
    applyStimulus(1'b1, tf, 1'b0, acc);
    checkOutput("fwd_tail", data_p_out, tf);
`endif
    applyStimulus(1'b0, '0, 1'b0, acc);
    checkOutput("pkt_done_void", Width'(data_void_p_out), Width'(1'b1));
    applyStimulus(1'b0, '0, 1'b0, acc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
